// File: rtl/alu4_pkg.sv
// Opcodes, FSM states and per-nibble opcode helpers shared by the word sequencer.
// cont_op turns a first-nibble opcode into the one that consumes the chained carry.
package alu4_pkg;

    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_ADC = 4'b0100;
    localparam logic [3:0] OP_SBB = 4'b0101;
    localparam logic [3:0] OP_ASR = 4'b1011;
    localparam logic [3:0] OP_SHL = 4'b1100;
    localparam logic [3:0] OP_SHR = 4'b1101;
    localparam logic [3:0] OP_RCL = 4'b1110;
    localparam logic [3:0] OP_RCR = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [3:0] cont_op(input logic [3:0] op_in);
        logic [3:0] res;
        case (op_in)
            OP_SHL:  res = OP_RCL;
            OP_SHR:  res = OP_RCR;
            OP_ASR:  res = OP_RCR;
            OP_ADD:  res = OP_ADC;
            OP_SUB:  res = OP_SBB;
            default: res = op_in;
        endcase
        return res;
    endfunction

    function automatic logic is_right_op(input logic [3:0] op_in);
        return (op_in == OP_SHR) || (op_in == OP_RCR) || (op_in == OP_ASR);
    endfunction

endpackage

// File: rtl/alu4_word_sequencer.sv
// Drives an external 4-bit ALU slice one nibble per clock to execute word-wide ops,
// chaining math/rotate carries between nibbles and assembling result and flags.
module alu4_word_sequencer
    import alu4_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [3:0]             op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    input  logic                   rcin,
    output logic                   ready,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   rcout,
    output logic                   ovf,
    output logic                   zero,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_op,
    output logic                   alu_cin,
    output logic                   alu_rcin,
    input  logic [3:0]             alu_out,
    input  logic                   alu_cout,
    input  logic                   alu_rcout,
    input  logic                   alu_ovf
);

    localparam int         W        = 4 * NIBBLES;
    localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

    state_e         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [3:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   result_q, result_d;
    logic           cout_q, cout_d;
    logic           rcout_q, rcout_d;
    logic           ovf_q, ovf_d;
    logic           zero_q, zero_d;
    logic           done_q, done_d;
    logic           ready_q, ready_d;
    logic [3:0]     alu_a_q, alu_a_d;
    logic [3:0]     alu_b_q, alu_b_d;
    logic [3:0]     alu_op_q, alu_op_d;
    logic           alu_cin_q, alu_cin_d;
    logic           alu_rcin_q, alu_rcin_d;

    logic           right_op;
    logic [2:0]     n_cur;
    logic [2:0]     n_nxt;
    logic [2:0]     n_first;

    function automatic logic [3:0] nib(input logic [W-1:0] word, input logic [2:0] sel);
        return 4'(word >> {sel, 2'b00});
    endfunction

    // Nibble positions: right ops walk MSB->LSB, all others LSB->MSB.
    always_comb begin
        right_op = is_right_op(op_q);
        if (right_op) begin
            n_cur = LAST_IDX - idx_q;
            n_nxt = LAST_IDX - idx_q - 3'd1;
        end else begin
            n_cur = idx_q;
            n_nxt = idx_q + 3'd1;
        end
        n_first = is_right_op(op) ? LAST_IDX : 3'd0;
    end

    // Next-state: ALU inputs are registered, so each edge presents the following nibble.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        cout_d     = cout_q;
        rcout_d    = rcout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        alu_a_d    = 4'h0;
        alu_b_d    = 4'h0;
        alu_op_d   = 4'h0;
        alu_cin_d  = 1'b0;
        alu_rcin_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    idx_d      = 3'd0;
                    op_d       = op;
                    a_d        = a;
                    b_d        = b;
                    alu_a_d    = nib(a, n_first);
                    alu_b_d    = nib(b, n_first);
                    alu_op_d   = op;
                    alu_cin_d  = cin;
                    alu_rcin_d = rcin;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int k = 0; k < NIBBLES; k++) begin
                    result_d[4*k +: 4] = (n_cur == 3'(k)) ? alu_out : result_q[4*k +: 4];
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    cout_d  = alu_cout;
                    rcout_d = alu_rcout;
                    ovf_d   = right_op ? 1'b0 : alu_ovf;
                    zero_d  = ~|result_d;
                end else begin
                    idx_d      = idx_q + 3'd1;
                    alu_a_d    = nib(a_q, n_nxt);
                    alu_b_d    = nib(b_q, n_nxt);
                    alu_op_d   = cont_op(op_q);
                    alu_cin_d  = alu_cout;
                    alu_rcin_d = alu_rcout;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d != ST_RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            op_q       <= 4'h0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            rcout_q    <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b1;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            alu_a_q    <= 4'h0;
            alu_b_q    <= 4'h0;
            alu_op_q   <= 4'h0;
            alu_cin_q  <= 1'b0;
            alu_rcin_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            rcout_q    <= rcout_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            alu_cin_q  <= alu_cin_d;
            alu_rcin_q <= alu_rcin_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign rcout    = rcout_q;
    assign ovf      = ovf_q;
    assign zero     = zero_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign alu_cin  = alu_cin_q;
    assign alu_rcin = alu_rcin_q;

endmodule

// File: tb/tb_alu4_word_sequencer.sv
// Self-checking bench: a nibble ALU model is attached to the sequencer and word results
// are compared against table constants and a word-level reference model.
module tb_alu4_word_sequencer;
    import alu4_pkg::*;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic           clk = 1'b0;
    logic           rst_n, start, cin, rcin;
    logic [3:0]     op;
    logic [W-1:0]   a, b;
    logic           ready, done, cout, rcout, ovf, zero;
    logic [W-1:0]   result;
    logic [3:0]     alu_a, alu_b, alu_op, alu_out;
    logic           alu_cin, alu_rcin, alu_cout, alu_rcout, alu_ovf;

    int total = 0;
    int bad   = 0;
    int lat;
    logic rdy_run;
    logic [3:0] seq_a [NIB];
    logic [3:0] seq_op[NIB];

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic         cin, rcin;
        logic [W-1:0] res;
        logic         cout, rcout, ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         cout, rcout, ovf;
    } exp_t;

    vec_t vecs[9];
    logic [3:0] ops[13];

    alu4_word_sequencer #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .cin(cin), .rcin(rcin), .ready(ready), .done(done), .result(result),
        .cout(cout), .rcout(rcout), .ovf(ovf), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_rcin(alu_rcin), .alu_out(alu_out), .alu_cout(alu_cout),
        .alu_rcout(alu_rcout), .alu_ovf(alu_ovf)
    );

    always #5 clk = ~clk;

    // Nibble ALU slice: math carry and rotate carry pass through ops that do not use them.
    logic [4:0] s4;
    logic [3:0] bx4;
    logic       ci4, msb4;
    always_comb begin
        alu_out   = alu_a;
        alu_cout  = alu_cin;
        alu_rcout = alu_rcin;
        alu_ovf   = 1'b0;
        bx4       = (alu_op == 4'b0001 || alu_op == 4'b0101) ? ~alu_b : alu_b;
        ci4       = (alu_op == 4'b0011) ? 1'b0 : ((alu_op == 4'b0001) ? 1'b1 : alu_cin);
        s4        = {1'b0, alu_a} + {1'b0, bx4} + {4'b0000, ci4};
        msb4      = (alu_op == 4'b1111) ? alu_rcin : ((alu_op == 4'b1011) ? alu_a[3] : 1'b0);
        case (alu_op)
            4'b0000: alu_out = alu_a & alu_b;
            4'b0010: alu_out = alu_a | alu_b;
            4'b0110: alu_out = alu_a ^ alu_b;
            4'b0001, 4'b0011, 4'b0100, 4'b0101: begin
                alu_out  = s4[3:0];
                alu_cout = s4[4];
                alu_ovf  = (alu_a[3] == bx4[3]) && (s4[3] != alu_a[3]);
            end
            4'b1100, 4'b1110: begin
                alu_out   = {alu_a[2:0], (alu_op == 4'b1110) ? alu_rcin : 1'b0};
                alu_rcout = alu_a[3];
                alu_ovf   = alu_a[3] ^ alu_a[2];
            end
            4'b1101, 4'b1111, 4'b1011: begin
                alu_out   = {msb4, alu_a[3:1]};
                alu_rcout = alu_a[0];
                alu_ovf   = alu_a[3] ^ msb4;
            end
            default: alu_out = alu_a;
        endcase
    end

    function automatic exp_t ref_model(input logic [3:0] o, input logic [W-1:0] x, y,
                                       input logic c, rc);
        exp_t e;
        logic [W:0]   s;
        logic [W-1:0] yy;
        logic         ci;
        e.res = x; e.cout = c; e.rcout = rc; e.ovf = 1'b0;
        yy = (o == 4'b0001 || o == 4'b0101) ? ~y : y;
        ci = (o == 4'b0011) ? 1'b0 : ((o == 4'b0001) ? 1'b1 : c);
        s  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ci};
        case (o)
            4'b0000: e.res = x & y;
            4'b0010: e.res = x | y;
            4'b0110: e.res = x ^ y;
            4'b0001, 4'b0011, 4'b0100, 4'b0101: begin
                e.res  = s[W-1:0];
                e.cout = s[W];
                e.ovf  = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
            end
            4'b1100: begin e.res = {x[W-2:0], 1'b0}; e.rcout = x[W-1]; e.ovf = x[W-1] ^ x[W-2]; end
            4'b1110: begin e.res = {x[W-2:0], rc};   e.rcout = x[W-1]; e.ovf = x[W-1] ^ x[W-2]; end
            4'b1101: begin e.res = {1'b0, x[W-1:1]};   e.rcout = x[0]; end
            4'b1111: begin e.res = {rc, x[W-1:1]};     e.rcout = x[0]; end
            4'b1011: begin e.res = {x[W-1], x[W-1:1]}; e.rcout = x[0]; end
            default: e.res = x;
        endcase
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, wait (bounded) for done at a negedge.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, y, input logic c, rc);
        @(posedge clk); #1;
        op = o; a = x; b = y; cin = c; rcin = rc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = ~x; b = ~y; cin = ~c; rcin = ~rc;
        lat = 0;
        rdy_run = 1'b0;
        for (int cyc = 1; cyc <= 3 * NIB && lat == 0; cyc++) begin
            @(negedge clk);
            if (cyc <= NIB) begin
                seq_a[cyc-1]  = alu_a;
                seq_op[cyc-1] = alu_op;
                if (ready) rdy_run = 1'b1;
            end
            if (done) lat = cyc;
        end
    endtask

    initial begin
        exp_t e;
        int   pulses;
        logic [W-1:0] x, y;
        logic [3:0]   o;
        logic         c, rc;

        vecs[0] = '{4'b1100, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{4'b1101, 16'h8001, 16'h0000, 1'b1, 1'b0, 16'h4000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{4'b1011, 16'h8004, 16'h0000, 1'b0, 1'b0, 16'hC002, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'b1111, 16'h0002, 16'h0000, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'b1100, 16'h8000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{4'b0011, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{4'b0001, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{4'b0100, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{4'b1110, 16'h4000, 16'h0000, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b1};
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                4'b0111, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

        rst_n = 1'b0; start = 1'b0; op = 4'h0; a = '0; b = '0; cin = 1'b0; rcin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_flags", {done, ready, zero, cout, rcout, ovf}, 6'b011000);
        chk("rst_alu", {alu_a, alu_b, alu_op, alu_cin, alu_rcin}, 0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].rcin);
            chk($sformatf("tbl%0d_latency", i), lat, NIB + 1);
            chk($sformatf("tbl%0d_result", i), result, vecs[i].res);
            chk($sformatf("tbl%0d_cout", i), cout, vecs[i].cout);
            chk($sformatf("tbl%0d_rcout", i), rcout, vecs[i].rcout);
            chk($sformatf("tbl%0d_ovf", i), ovf, vecs[i].ovf);
            chk($sformatf("tbl%0d_zero", i), zero, (vecs[i].res == 16'h0000) ? 1 : 0);
            chk($sformatf("tbl%0d_ready_done", i), ready, 1);
            chk($sformatf("tbl%0d_ready_run", i), rdy_run, 0);
            @(negedge clk);
            chk($sformatf("tbl%0d_done_pulse", i), done, 0);
            chk($sformatf("tbl%0d_hold", i), result, vecs[i].res);
        end

        run_op(4'b1101, 16'h8001, 16'h0000, 1'b0, 1'b0);
        chk("shr_seq_a", {seq_a[0], seq_a[1], seq_a[2], seq_a[3]}, 16'h8001);
        run_op(4'b1011, 16'h8004, 16'h0000, 1'b0, 1'b0);
        chk("asr_seq_op", {seq_op[0], seq_op[1], seq_op[2], seq_op[3]}, 16'hBFFF);
        chk("asr_result", result, 16'hC002);

        // start held through RUN: one op per NIB+1 cycles, second accepted in DONE
        @(posedge clk); #1;
        op = 4'b0011; a = 16'h0001; b = 16'h0002; cin = 1'b0; rcin = 1'b0; start = 1'b1;
        pulses = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin a = 16'h0005; b = 16'h0006; end
            if (cyc == 6) start = 1'b0;
            @(negedge clk);
            if (done) begin
                pulses++;
                if (cyc == NIB + 1) chk("b2b_first", result, 16'h0003);
                else if (cyc == 2 * (NIB + 1)) chk("b2b_second", result, 16'h000B);
                else chk("b2b_pulse_cycle", cyc, 0);
            end
        end
        chk("b2b_pulses", pulses, 2);

        // reset while idx=2 abandons the op
        @(posedge clk); #1;
        op = 4'b0011; a = 16'h1234; b = 16'h1111; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {done, ready, zero, cout, rcout, ovf}, 6'b011000);
        chk("midrst_alu", {alu_a, alu_b, alu_op, alu_cin, alu_rcin}, 0);
        pulses = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("midrst_no_done", pulses, 0);

        for (int i = 0; i < 150; i++) begin
            o  = ops[$urandom_range(0, 12)];
            x  = W'($urandom);
            y  = W'($urandom);
            c  = 1'($urandom);
            rc = 1'($urandom);
            run_op(o, x, y, c, rc);
            e = ref_model(o, x, y, c, rc);
            chk($sformatf("rnd%0d_op%h_latency", i, o), lat, NIB + 1);
            chk($sformatf("rnd%0d_op%h_result", i, o), result, e.res);
            chk($sformatf("rnd%0d_op%h_cout", i, o), cout, e.cout);
            chk($sformatf("rnd%0d_op%h_rcout", i, o), rcout, e.rcout);
            chk($sformatf("rnd%0d_op%h_ovf", i, o), ovf, e.ovf);
            chk($sformatf("rnd%0d_op%h_zero", i, o), zero, (e.res == '0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
